// File: rtl/ps2_key_ctrl.sv
// Pops PS/2 scan-code bytes from the receive FIFO, decodes make/break/E0 and tracks the held key.
// Key outputs update 2 edges after a byte is presented (one byte per 2 cycles); overflow flushes the FIFO.
module ps2_key_ctrl #(
  parameter int COUNT_W          = 8,
  parameter bit BLANK_ON_RELEASE = 1'b1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               ready,
  input  logic [7:0]         data,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic [COUNT_W-1:0] counts,
  output logic               pressed,
  output logic               disp_en
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  logic [1:0] state;
  logic [7:0] byte_q;
  logic       brk_f;
  logic       ext_f;
  logic       same_key;

  assign same_key = (byte_q == key_code) && (ext_f == key_ext);

  // The pop strobe is decoded straight from the state register so it coincides with the cycle the
  // head byte is captured; gating with clrn keeps a reset cycle from consuming a byte.
  assign nextdata_n = ~(clrn & ready & (((state == IDLE) & ~overflow) | (state == FLUSH)));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      byte_q   <= 8'h00;
      brk_f    <= 1'b0;
      ext_f    <= 1'b0;
      key_code <= 8'h00;
      key_ext  <= 1'b0;
      counts   <= '0;
      pressed  <= 1'b0;
      disp_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (overflow) begin
            state <= FLUSH;
          end else if (ready) begin
            byte_q <= data;
            state  <= DECODE;
          end
        end
        DECODE: begin
          state <= IDLE;
          if (byte_q == BRK_CODE) begin
            brk_f <= 1'b1;
          end else if (byte_q == EXT_CODE) begin
            ext_f <= 1'b1;
          end else if (brk_f) begin
            // A break for any key other than the tracked one is dropped.
            if (same_key) begin
              pressed <= 1'b0;
              if (BLANK_ON_RELEASE) disp_en <= 1'b0;
            end
            brk_f <= 1'b0;
            ext_f <= 1'b0;
          end else if (pressed && same_key) begin
            ext_f <= 1'b0;
          end else begin
            key_code <= byte_q;
            key_ext  <= ext_f;
            pressed  <= 1'b1;
            disp_en  <= 1'b1;
            counts   <= counts + COUNT_W'(1);
            ext_f    <= 1'b0;
          end
        end
        FLUSH: begin
          if (!ready && !overflow) begin
            brk_f   <= 1'b0;
            ext_f   <= 1'b0;
            pressed <= 1'b0;
            if (BLANK_ON_RELEASE) disp_en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized bench for ps2_key_ctrl: a queue-based FIFO model feeds bytes, a byte-level key model predicts outputs.
module tb_ps2_key_ctrl;
  localparam int CW    = 8;
  localparam bit BLANK = 1'b1;

  logic          clk = 1'b0;
  logic          clrn;
  logic          ready;
  logic [7:0]    data;
  logic          overflow;
  logic          nextdata_n;
  logic [7:0]    key_code;
  logic          key_ext;
  logic [CW-1:0] counts;
  logic          pressed;
  logic          disp_en;

  ps2_key_ctrl #(.COUNT_W(CW), .BLANK_ON_RELEASE(BLANK)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .counts(counts), .pressed(pressed), .disp_en(disp_en)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int strobes = 0;
  int empty_pops = 0;
  int gap_err = 0;
  int last_pop = -1;
  bit flushing = 1'b0;
  bit last_nd = 1'b1;

  logic [7:0] m_code;
  bit m_ext, m_pr, m_de, m_brk, m_extf;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic refresh();
    ready = (fifo_q.size() > 0);
    data  = ready ? fifo_q[0] : 8'h00;
  endtask

  // One clock: sample the strobe mid-cycle, let the FIFO model pop on the edge, then update its head.
  task automatic tick(output bit popped);
    @(negedge clk);
    last_nd = nextdata_n;
    if (!last_nd) begin
      strobes++;
      if (!ready) empty_pops++;
      if (!flushing && last_pop >= 0 && cyc - last_pop < 2) gap_err++;
      last_pop = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    popped = !last_nd && fifo_q.size() > 0;
    if (popped) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ext = 0; m_pr = 0; m_de = 0; m_brk = 0; m_extf = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_extf = 1;
    else begin
      if (m_brk) begin
        if (b == m_code && m_extf == m_ext) begin
          m_pr = 0;
          if (BLANK) m_de = 0;
        end
      end else if (!(m_pr && b == m_code && m_extf == m_ext)) begin
        m_code = b; m_ext = m_extf; m_pr = 1; m_de = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      m_brk = 0; m_extf = 0;
    end
  endtask

  task automatic model_flush();
    m_pr = 0; m_brk = 0; m_extf = 0;
    if (BLANK) m_de = 0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".code"}, key_code, m_code);
    check({tag, ".ext"},  key_ext,  m_ext);
    check({tag, ".cnt"},  counts,   m_cnt);
    check({tag, ".prs"},  pressed,  m_pr);
    check({tag, ".den"},  disp_en,  m_de);
  endtask

  // Waits for the head byte to be popped, then lets it decode and compares against the model.
  task automatic run_head(input string tag, input logic [7:0] b);
    bit p;
    int n;
    p = 0; n = 0;
    while (!p && n < 20) begin tick(p); n++; end
    check({tag, ".popped"}, p, 1);
    model_byte(b);
    tick(p);
    check_outs(tag);
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
    run_head(tag, b);
  endtask

  task automatic flush_run(input string tag, input int k);
    bit p;
    int n, s0, f, l, exp_pops;
    bit first_nd;
    for (int j = 0; j < k; j++) fifo_q.push_back(8'($urandom_range(0, 255)));
    exp_pops = fifo_q.size();
    overflow = 1'b1;
    refresh();
    flushing = 1'b1;
    s0 = strobes; f = -1; l = -1; n = 0;
    tick(p);
    first_nd = last_nd;
    if (!last_nd) begin f = cyc; l = cyc; end
    while (fifo_q.size() > 0 && n < 50) begin
      tick(p);
      n++;
      if (!last_nd) begin if (f < 0) f = cyc; l = cyc; end
    end
    overflow = 1'b0;
    tick(p);
    tick(p);
    flushing = 1'b0;
    model_flush();
    check({tag, ".first_no_pop"}, first_nd, 1);
    check({tag, ".pops"}, strobes - s0, exp_pops);
    if (exp_pops > 0) check({tag, ".consecutive"}, l - f, exp_pops - 1);
    check_outs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b0;
    @(negedge clk) clrn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h1C;
      1: return 8'h32;
      2: return 8'h75;
      3, 4: return 8'hF0;
      5: return 8'hE0;
      6: return 8'h2A;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    int s0, n, mode, len;
    logic [7:0] b;
    logic [7:0] bs[$];

    clrn = 1'b0; overflow = 1'b0; ready = 1'b0; data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.nd",   nextdata_n, 1);
    check("rst.code", key_code, 8'h00);
    check("rst.ext",  key_ext, 0);
    check("rst.cnt",  counts, 0);
    check("rst.prs",  pressed, 0);
    check("rst.den",  disp_en, 0);
    @(negedge clk) clrn = 1'b1;
    @(posedge clk);
    #1;

    // First make: one strobe, outputs two edges after the byte appears.
    fifo_q.push_back(8'h1C);
    refresh();
    tick(p);
    check("t1.strobe", last_nd, 0);
    check("t1.pop", p, 1);
    check("t1.code_pending", key_code, 8'h00);
    tick(p);
    check("t1.decode_no_strobe", last_nd, 1);
    model_byte(8'h1C);
    check_outs("t1");
    check("t1.cnt_one", counts, 1);

    // Typematic repeats then release.
    s0 = strobes;
    do_reset();
    send("t2.a", 8'h1C);
    send("t2.b", 8'h1C);
    send("t2.c", 8'h1C);
    send("t2.d", 8'hF0);
    send("t2.e", 8'h1C);
    check("t2.strobes", strobes - s0, 5);
    check("t2.cnt", counts, 1);
    check("t2.released", pressed, 0);

    // Extended key; a non-extended break against it is ignored.
    send("t3.a", 8'hE0);
    send("t3.b", 8'h75);
    check("t3.ext", key_ext, 1);
    send("t3.c", 8'hF0);
    send("t3.d", 8'h75);
    check("t3.ignored", pressed, 1);
    send("t3.e", 8'hE0);
    send("t3.f", 8'hF0);
    send("t3.g", 8'h75);
    check("t3.released", pressed, 0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++) send("t4.fill", (i % 2 == 0) ? 8'h10 : 8'h11);
    check("t4.ff", counts, 8'hFF);
    send("t4.wrap", 8'h1C);
    check("t4.zero", counts, 8'h00);
    send("t4.brk", 8'hF0);
    send("t4.rel", 8'h1C);
    send("t4.next", 8'h32);
    check("t4.one", counts, 8'h01);

    // Overflow flush while 1C is held.
    send("t5.make", 8'h1C);
    flush_run("t5.flush", 3);
    check("t5.prs", pressed, 0);
    check("t5.den", disp_en, 0);
    send("t5.idle", 8'h1C);

    // Overflow arriving during DECODE: the byte still decodes, then the FIFO is flushed.
    fifo_q.push_back(8'h2A);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h12);
    refresh();
    tick(p);
    check("t5b.pop", p, 1);
    model_byte(8'h2A);
    flush_run("t5b.flush", 0);

    // Reset during DECODE of a make: immediate reset values, head byte not popped.
    fifo_q.push_back(8'h1C);
    refresh();
    p = 0; n = 0;
    while (!p && n < 20) begin tick(p); n++; end
    check("t6.pop", p, 1);
    fifo_q.push_back(8'h4B);
    refresh();
    clrn = 1'b0;
    #1;
    check("t6.nd",   nextdata_n, 1);
    check("t6.code", key_code, 8'h00);
    check("t6.ext",  key_ext, 0);
    check("t6.cnt",  counts, 0);
    check("t6.prs",  pressed, 0);
    check("t6.den",  disp_en, 0);
    tick(p);
    check("t6.no_pop", p, 0);
    @(negedge clk) clrn = 1'b1;
    model_reset();
    run_head("t6.after", 8'h4B);

    // Randomized mix of back-to-back bursts, single bytes and overflow flushes.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
        len = $urandom_range(1, 6);
        bs.delete();
        for (int j = 0; j < len; j++) begin
          b = pick();
          bs.push_back(b);
          fifo_q.push_back(b);
        end
        refresh();
        n = 0;
        while (fifo_q.size() > 0 && n < 200) begin tick(p); n++; end
        check("rnd.drain", fifo_q.size(), 0);
        foreach (bs[j]) model_byte(bs[j]);
        tick(p);
        tick(p);
        check_outs("rnd.burst");
      end else if (mode < 8) begin
        send("rnd.one", pick());
      end else begin
        flush_run("rnd.flush", $urandom_range(0, 4));
      end
    end

    check("gap_ok", gap_err, 0);
    check("no_empty_pop", empty_pops, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
